if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Parametrised successor of the single-register PC stage. It generates the sequential PC and issues fetch requests over a valid/ready instruction-memory port, with a bounded number of requests in flight. In-order responses are buffered with their PCs in a fetch queue that feeds decode through a valid/ready handshake. It sits between the branch/jump resolution logic, which supplies redirects, and the decode stage.

Parameters:
XLEN, 32, PC and instruction width in bits
RESET_PC, 32'h0000_3000, PC value loaded on reset
PC_STEP, 4, sequential PC increment in bytes
FQ_DEPTH, 4, fetch-queue entries; power of 2, >=2
MAX_OUT, 2, maximum outstanding imem requests; 1..FQ_DEPTH

Ports:
clk_cpu  in  1  CPU clock; all state updates on its rising edge
rstn  in  1  asynchronous, active-low reset
stall  in  1  freeze PC and request issue; queue keeps draining
redirect_valid  in  1  taken branch/jump; replaces the old PCSrc path
redirect_pc  in  XLEN  target PC, replaces the old Addsum path
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address (= pc_q)
imem_rsp_valid  in  1  in-order response, one per accepted request
imem_rsp_data  in  XLEN  instruction word
dec_valid  out  1  queue head valid
dec_ready  in  1  decode accepts head
dec_pc  out  XLEN  PC of head instruction
dec_insn  out  XLEN  head instruction
pc  out  XLEN  current fetch PC (debug/serial-unit visibility)
fq_count  out  $clog2(FQ_DEPTH)+1  live queue occupancy

Behaviour:
- Reset (rstn low, asynchronous, any time, including mid-transaction): pc_q=RESET_PC, out_cnt=0, drop_cnt=0, queue and tag FIFO empty. Resulting outputs: imem_req_valid=0, dec_valid=0, fq_count=0, pc=RESET_PC. Memory responses arriving after reset release without a matching request are a protocol error; behaviour is undefined and the bench must not drive them.
- Credit: live = fq_count + (out_cnt - drop_cnt).
- imem_req_valid = !redirect_valid && !stall && out_cnt<MAX_OUT && live<FQ_DEPTH. These credits guarantee the queue never overflows.
- Request fire (valid&&ready): push pc_q into the tag FIFO; pc_q <= pc_q+PC_STEP, wrapping modulo 2^XLEN.
- Response handling:
  - drop_cnt>0: discard the response; drop_cnt-1; pop the tag FIFO.
  - Otherwise: pop the tag PC and push {tag_pc, rsp_data} into the queue.
  - The entry is visible on dec_* the next cycle (1-cycle latency).
- out_cnt_next = out_cnt + req_fire - rsp_valid.
- Redirect (priority over stall and sequential increment):
  - pc_q <= redirect_pc.
  - Fetch queue flushed.
  - drop_cnt <= out_cnt_next - (response accepted into queue this cycle ? 0 : 0), i.e. every request still outstanding after this cycle becomes stale. A response arriving in the redirect cycle is itself discarded.
  - dec_valid is forced 0 during the redirect cycle; a dec_ready pop in that cycle is ignored.
  - Stale tags stay in the tag FIFO and are popped by the dropped responses.
- Stall: pc_q holds and no request is issued. Responses and the dec handshake continue. A redirect during stall still loads pc_q.
- Queue: dec_valid = (fq_count!=0) && !redirect_valid. Pop on dec_valid&&dec_ready. A simultaneous push and pop keeps the count unchanged. Full and empty are flagged from a count of width $clog2(FQ_DEPTH)+1. Pointers wrap modulo FQ_DEPTH.
- Back-to-back redirects: each one recomputes drop_cnt from the current out_cnt_next, so no stale response ever leaks.

Decomposition:
- Package if_pkg holds:
  - XLEN default, RESET_PC and PC_STEP constants.
  - fq_entry_t struct {pc, insn}.
- Sub-module fetch_fifo (params WIDTH, DEPTH; push/pop/flush/full/empty/count). It is instantiated twice:
  - the tag FIFO, DEPTH=MAX_OUT, never flushed;
  - the fetch queue, DEPTH=FQ_DEPTH, flushed on redirect.

Test Plan:
1. Reset: hold rstn=0 mid-fetch -> pc=0x3000, imem_req_valid=0, dec_valid=0. Release with ready=1 -> requests to 0x3000, 0x3004 in consecutive cycles.
2. Streaming: memory with 1-cycle latency and dec_ready=1 -> dec_pc sequence 0x3000, 0x3004, 0x3008, each with its matching insn; throughput one instruction per cycle.
3. Backpressure: dec_ready=0 -> exactly FQ_DEPTH=4 instructions accepted; imem_req_valid drops; fq_count=4. Then dec_ready=1 -> resumes with no loss or duplication.
4. Redirect with 2 outstanding requests (0x3008, 0x300C): redirect_pc=0x4000 -> both responses discarded; first dec_pc=0x4000; queue empty the cycle after the redirect.
5. Stall plus redirect in the same cycle, target 0x5000 -> pc=0x5000 next cycle; no request issued until stall falls.
6. Wrap-around: redirect to 0xFFFF_FFFC -> next request address 0x0000_0000.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared constants and the fetch-queue entry layout for the instruction fetch unit.
package if_pkg;

  localparam int unsigned XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam int unsigned PC_STEP_DEFAULT  = 4;

  // Queue entries are stored as {pc, insn}; this struct documents that layout.
  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] insn;
  } fq_entry_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory and decode handshake bundle; master is the fetch unit side.
interface if_fetch_unit_if #(
  parameter int unsigned XLEN = 32
);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            dec_valid;
  logic            dec_ready;
  logic [XLEN-1:0] dec_pc;
  logic [XLEN-1:0] dec_insn;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output dec_valid, dec_pc, dec_insn,
    input  dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  dec_valid, dec_pc, dec_insn,
    output dec_ready
  );

endinterface

// File: rtl/if_fetch_unit_fifo.sv
// Small synchronous FIFO with flush; used for the in-flight tag FIFO and the fetch queue.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  // Explicit wrap so non-power-of-two depths (e.g. MAX_OUT=3) also work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Sequential PC generator issuing credit-limited imem requests; in-order responses
// are paired with their PCs and buffered in a fetch queue feeding decode.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int unsigned     PC_STEP  = PC_STEP_DEFAULT,
  parameter int unsigned     FQ_DEPTH = 4,
  parameter int unsigned     MAX_OUT  = 2
) (
  input  logic                      clk_cpu,
  input  logic                      rstn,
  input  logic                      stall,
  input  logic                      redirect_valid,
  input  logic [XLEN-1:0]           redirect_pc,
  if_fetch_unit_if.master           bus,
  output logic [XLEN-1:0]           pc,
  output logic [$clog2(FQ_DEPTH):0] fq_count
);

  localparam int unsigned OCW = $clog2(MAX_OUT) + 1;
  localparam int unsigned FCW = $clog2(FQ_DEPTH) + 1;
  localparam int unsigned LW  = FCW + 1;

  logic [XLEN-1:0]   pc_q, pc_d, tag_pc;
  logic [OCW-1:0]    out_cnt, out_cnt_next, drop_cnt_q, drop_cnt_d;
  logic [LW-1:0]     live;
  logic [2*XLEN-1:0] fq_head;
  logic              tag_full, tag_empty, fq_full, fq_empty;
  logic              req_valid, req_fire, rsp_pop, rsp_keep, fq_push, fq_pop;

  // Live credits: queued entries plus outstanding requests whose responses will be kept.
  assign live = LW'(fq_count) + LW'(out_cnt) - LW'(drop_cnt_q);

  // Gated by rstn so no request is presented while reset is held.
  assign req_valid = rstn && !redirect_valid && !stall && !tag_full
                     && (live < LW'(FQ_DEPTH));
  assign req_fire  = req_valid && bus.imem_req_ready;

  assign rsp_pop  = bus.imem_rsp_valid && !tag_empty;
  assign rsp_keep = rsp_pop && (drop_cnt_q == '0) && !redirect_valid;
  assign fq_push  = rsp_keep && (!fq_full || fq_pop);

  assign bus.dec_valid = !fq_empty && !redirect_valid;
  assign fq_pop        = bus.dec_valid && bus.dec_ready;

  assign out_cnt_next = out_cnt + OCW'(req_fire) - OCW'(rsp_pop);

  always_comb begin
    pc_d       = pc_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      pc_d       = redirect_pc;
      drop_cnt_d = out_cnt_next;
    end else begin
      if (req_fire) pc_d = pc_q + XLEN'(PC_STEP);
      if (rsp_pop && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - OCW'(1);
    end
  end

  always_ff @(posedge clk_cpu or negedge rstn) begin
    if (!rstn) begin
      pc_q       <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Occupancy of the tag FIFO is the outstanding-request count.
  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk_i   (clk_cpu),
    .rst_ni  (rstn),
    .push_i  (req_fire),
    .pop_i   (rsp_pop),
    .flush_i (1'b0),
    .wdata_i (pc_q),
    .rdata_o (tag_pc),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (out_cnt)
  );

  fetch_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (FQ_DEPTH)
  ) u_fetch_q (
    .clk_i   (clk_cpu),
    .rst_ni  (rstn),
    .push_i  (fq_push),
    .pop_i   (fq_pop),
    .flush_i (redirect_valid),
    .wdata_i ({tag_pc, bus.imem_rsp_data}),
    .rdata_o (fq_head),
    .full_o  (fq_full),
    .empty_o (fq_empty),
    .count_o (fq_count)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.dec_pc         = fq_head[2*XLEN-1:XLEN];
  assign bus.dec_insn       = fq_head[XLEN-1:0];
  assign pc                 = pc_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit against a queue-based fetch/decode reference model.
module tb_if_fetch_unit;
  import if_pkg::*;

  localparam int unsigned FQD = 4;
  localparam int unsigned MO  = 2;

  logic        clk_cpu = 1'b0;
  logic        rstn = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] pc;
  logic [2:0]  fq_count;

  if_fetch_unit_if #(.XLEN(32)) bus ();

  if_fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0000_3000),
    .PC_STEP  (4),
    .FQ_DEPTH (FQD),
    .MAX_OUT  (MO)
  ) dut (
    .clk_cpu        (clk_cpu),
    .rstn           (rstn),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus),
    .pc             (pc),
    .fq_count       (fq_count)
  );

  always #5 clk_cpu = ~clk_cpu;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: fetch PC, in-flight requests (stale flag), expected decode queue.
  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } infl_t;

  infl_t       infl[$];
  fq_entry_t   expq[$];
  logic [31:0] m_pc;

  // Memory environment: accepted addresses and the cycle they were accepted.
  logic [31:0] mem_addr[$];
  int          mem_cyc[$];
  int          cyc = 0;
  int          ready_pct = 100;
  int          rsp_pct = 100;
  int          dec_pct = 100;

  function automatic logic [31:0] insn_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic model_reset();
    infl.delete();
    expq.delete();
    mem_addr.delete();
    mem_cyc.delete();
    m_pc = 32'h0000_3000;
  endtask

  task automatic step(input bit rd, input logic [31:0] rpc, input bit st);
    int        fresh;
    bit        exp_req, exp_dec, rsp;
    infl_t     f;
    fq_entry_t e;
    redirect_valid     = rd;
    redirect_pc        = rpc;
    stall              = st;
    bus.imem_req_ready = ($urandom_range(99) < ready_pct);
    bus.dec_ready      = ($urandom_range(99) < dec_pct);
    rsp = (mem_addr.size() != 0) && (mem_cyc[0] < cyc) && ($urandom_range(99) < rsp_pct);
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rsp ? insn_of(mem_addr[0]) : $urandom;
    if (rsp) begin
      void'(mem_addr.pop_front());
      void'(mem_cyc.pop_front());
    end
    #1;
    fresh = 0;
    foreach (infl[i]) if (!infl[i].stale) fresh++;
    exp_req = !rd && !st && (infl.size() < MO) && ((expq.size() + fresh) < FQD);
    exp_dec = (expq.size() != 0) && !rd;
    check("pc", pc, m_pc);
    check("req_valid", bus.imem_req_valid, exp_req);
    if (exp_req) check("req_addr", bus.imem_req_addr, m_pc);
    check("fq_count", fq_count, expq.size());
    check("dec_valid", bus.dec_valid, exp_dec);
    if (exp_dec) begin
      check("dec_pc", bus.dec_pc, expq[0].pc);
      check("dec_insn", bus.dec_insn, expq[0].insn);
    end
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      mem_addr.push_back(bus.imem_req_addr);
      mem_cyc.push_back(cyc);
    end
    if (exp_dec && bus.dec_ready) void'(expq.pop_front());
    if (rsp && infl.size() != 0) begin
      f = infl.pop_front();
      if (!f.stale && !rd) begin
        e.pc   = f.addr;
        e.insn = insn_of(f.addr);
        expq.push_back(e);
      end
    end
    if (rd) begin
      expq.delete();
      foreach (infl[i]) infl[i].stale = 1'b1;
      m_pc = rpc;
    end else if (exp_req && bus.imem_req_ready) begin
      f.addr  = m_pc;
      f.stale = 1'b0;
      infl.push_back(f);
      m_pc = m_pc + 32'd4;
    end
    @(posedge clk_cpu);
    @(negedge clk_cpu);
    cyc++;
  endtask

  task automatic reset_mid();
    #3;
    rstn               = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    redirect_valid     = 1'b0;
    stall              = 1'b0;
    bus.imem_req_ready = 1'b1;
    #1;
    check("rst_pc", pc, 32'h0000_3000);
    check("rst_req_valid", bus.imem_req_valid, 1'b0);
    check("rst_dec_valid", bus.dec_valid, 1'b0);
    check("rst_fq_count", fq_count, 0);
    model_reset();
    @(negedge clk_cpu);
    @(negedge clk_cpu);
    rstn = 1'b1;
  endtask

  initial begin
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.dec_ready      = 1'b0;
    model_reset();
    #1 rstn = 1'b0;
    @(negedge clk_cpu);
    check("init_pc", pc, 32'h0000_3000);
    check("init_req_valid", bus.imem_req_valid, 1'b0);
    check("init_dec_valid", bus.dec_valid, 1'b0);
    check("init_fq_count", fq_count, 0);
    rstn = 1'b1;

    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0);
    reset_mid();
    for (int i = 0; i < 30; i++) step(1'b0, '0, 1'b0);

    dec_pct = 0;
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b0);
    check("bp_fq_count", fq_count, FQD);
    check("bp_req_stop", bus.imem_req_valid, 1'b0);
    dec_pct = 100;
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b0);

    rsp_pct = 0;
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
    step(1'b1, 32'h0000_4000, 1'b0);
    check("redir_fq_empty", fq_count, 0);
    rsp_pct = 100;
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b0);

    step(1'b1, 32'h0000_5000, 1'b1);
    check("stall_redir_pc", pc, 32'h0000_5000);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0);

    step(1'b1, 32'hFFFF_FFFC, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b0);

    ready_pct = 70;
    rsp_pct   = 60;
    dec_pct   = 70;
    for (int i = 1; i <= 3000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      step($urandom_range(99) < 6, tgt, $urandom_range(99) < 15);
      if (i % 700 == 0) reset_mid();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
